bicubic_tap_fetch: RTL and testbench
====================================

Name: bicubic_tap_fetch

Overview:
- Upstream operand-fetch stage for the bicubic horizontal interpolator.
- Walks every target column of every source row of the selected ROI and computes the integer source index and the fractional position exactly, using incremental arithmetic with no divider.
- Fetches the 4 neighbouring source pixels (edge-clamped) from ImgROM through a reusing 4-tap window.
- Hands one tap set per target pixel downstream over a valid/ready handshake.

Parameters:
- IMG_W, 100, ImgROM row pitch in pixels.
- ROM_AW, 14, ImgROM address width.

Ports:
- CLK  in  1  clock
- RST  in  1  reset
- start  in  1  1-cycle pulse; sampled only in IDLE
- V0  in  7  ROI top row
- H0  in  7  ROI left column
- SW  in  5  source ROI width
- SH  in  5  source ROI height (rows processed)
- TW  in  6  target width
- rom_cen  out  1  ImgROM chip enable, active low
- rom_a  out  ROM_AW  ImgROM address
- rom_q  in  8  ImgROM data, valid 1 CLK after the rom_cen=0 cycle
- out_valid  out  1  tap set valid
- out_ready  in  1  downstream accept
- out_taps  out  32  {p3,p2,p1,p0}; p0 = column i-1 … p3 = column i+2
- out_num  out  6  fraction numerator, < out_den
- out_den  out  6  TW-1
- out_x  out  6  target column
- out_y  out  5  source row
- out_last  out  1  final pixel of the ROI
- busy  out  1  not IDLE
- done  out  1  1-cycle pulse at end of ROI
- err  out  1  sticky until next start; illegal geometry

Behaviour:
- Reset: RST is asynchronous, active-high; clock is CLK. All state returns to IDLE. Output reset values: rom_cen=1, rom_a=0, out_valid=0, out_taps=0, out_num=0, out_den=0, out_x=0, out_y=0, out_last=0, busy=0, done=0, err=0, window invalid.
- Reset mid-operation: aborts immediately; no done pulse is issued.
- State IDLE:
  - On start, latch V0/H0/SW/SH/TW and clear err.
  - If SW<2 or TW<2: set err=1, go to FIN.
  - Otherwise: r=0, x=0, acc=0, i=0, window invalid; go to FETCH.
- Position arithmetic:
  - acc holds x·(SW-1) mod (TW-1); i = floor(x·(SW-1)/(TW-1)).
  - On advance: acc += SW-1, then ADVANCE subtracts TW-1 once per cycle while acc ≥ TW-1, incrementing i and the shift count k each time.
  - acc is 7 bits and never exceeds 2·max(SW,TW).
- Window:
  - Holds logical columns i-1 … i+2. Physical column = clamp(c, 0, SW-1).
  - Address = (V0+r)·IMG_W + H0 + physical column.
- State FETCH:
  - If the window is invalid or k ≥ 4, issue all 4 reads. Otherwise shift the window down by k and read only the k new top taps. k=0 issues zero reads.
  - One read per cycle: rom_cen=0 for exactly the read cycles; rom_q is captured in the following cycle.
  - After the last capture, go to PRESENT.
- State PRESENT:
  - out_valid=1; all out_* held stable until out_ready.
  - Handshake completes in the cycle where out_valid & out_ready.
  - If x<TW-1: x+1, go to ADVANCE.
  - Else if r<SH-1: r+1, x=0, acc=0, i=0, window invalid (no reuse across rows), go to FETCH.
  - Else go to FIN.
- out_last = (x==TW-1 && r==SH-1).
- State FIN: done=1 for one cycle, then IDLE.
- busy=1 in every state except IDLE.
- start while busy is ignored.
- No ROM access occurs while stalled in PRESENT.
- Boundary: x=TW-1 always yields i=SW-1 and num=0.

Decomposition:
- Shared package bicubic_pkg: IMG_W, ROM_AW, state encoding, tap-set packing order. The downstream interpolator imports the same package.
- One natural sub-module, tap_window4: a 4×8 shift/load register with a k-shift port and an indexed write.

Test Plan:
- Upscale, V0=10, H0=20, SW=4, TW=7, SH=1:
  - x=0: reads 1020,1020,1021,1022; num=0; den=6.
  - x=1: zero reads; num=3.
  - x=2: one read 1023; i=1, num=0.
  - x=6: taps cols 2,3,3,3; out_last=1, then done pulse.
- Downscale, SW=8, TW=3:
  - x=1: i=3, num=1, k=3 → 3 reads.
  - x=2: i=7, k=4 → full refetch; taps cols 6,7,7,7.
- Backpressure: out_ready low for 5 cycles in PRESENT → outputs constant, rom_cen=1 throughout; accept on cycle 6.
- Multi-row, SH=3, TW=2:
  - Each row starts with 4 fresh reads at base (V0+r)·100.
  - out_y steps 0,1,2; exactly 6 handshakes, then one done.
- Illegal geometry, SW=1: err=1, done one cycle after FIN entry, no ROM access, no out_valid.
- RST asserted mid-FETCH → next edge IDLE, rom_cen=1, out_valid=0; a fresh start reproduces the first scenario exactly.

Source files
------------

// File: rtl/bicubic_pkg.sv
// Shared definitions for the bicubic horizontal interpolator path.
// Holds ROM geometry, fetch FSM encoding and tap-set packing order.
package bicubic_pkg;

  localparam int IMG_W  = 100;
  localparam int ROM_AW = 14;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_PRESENT,
    S_ADVANCE,
    S_FIN
  } state_t;

  // p0 is the leftmost column (i-1), p3 the rightmost (i+2)
  function automatic logic [31:0] pack_taps(
    input logic [7:0] p0,
    input logic [7:0] p1,
    input logic [7:0] p2,
    input logic [7:0] p3
  );
    return {p3, p2, p1, p0};
  endfunction

endpackage

// File: rtl/tap_window4.sv
// 4 x 8-bit tap window: shift down by k (1..3) or write one slot.
// Ports: CLK/RST, shift_en/shift_k, wr_en/wr_idx/wr_data, taps out.
module tap_window4
  import bicubic_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        shift_en,
  input  logic [1:0]  shift_k,
  input  logic        wr_en,
  input  logic [1:0]  wr_idx,
  input  logic [7:0]  wr_data,
  output logic [31:0] taps
);

  logic [7:0] w_q [4];
  logic [7:0] w_d [4];
  logic [2:0] src;

  always_comb begin
    w_d = w_q;
    src = '0;
    if (shift_en) begin
      for (int j = 0; j < 4; j++) begin
        src = 3'(j) + {1'b0, shift_k};
        if (!src[2]) w_d[j] = w_q[src[1:0]];
      end
    end
    if (wr_en) w_d[wr_idx] = wr_data;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int j = 0; j < 4; j++) w_q[j] <= '0;
    end else begin
      w_q <= w_d;
    end
  end

  assign taps = pack_taps(w_q[0], w_q[1], w_q[2], w_q[3]);

endmodule

// File: rtl/bicubic_tap_fetch.sv
// Walks an ROI, tracks source index/fraction incrementally, fetches taps.
// Ports: start/geometry in, ImgROM (cen/a/q), valid/ready tap-set out.
module bicubic_tap_fetch #(
  parameter int IMG_W  = bicubic_pkg::IMG_W,
  parameter int ROM_AW = bicubic_pkg::ROM_AW
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic [6:0]        V0,
  input  logic [6:0]        H0,
  input  logic [4:0]        SW,
  input  logic [4:0]        SH,
  input  logic [5:0]        TW,
  output logic              rom_cen,
  output logic [ROM_AW-1:0] rom_a,
  input  logic [7:0]        rom_q,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_taps,
  output logic [5:0]        out_num,
  output logic [5:0]        out_den,
  output logic [5:0]        out_x,
  output logic [4:0]        out_y,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              err
);
  import bicubic_pkg::*;

  state_t state_q, state_d;
  logic [6:0] v0_q, v0_d, h0_q, h0_d;
  logic [4:0] step_q, step_d, sh_q, sh_d;
  logic [5:0] den_q, den_d;
  logic [4:0] r_q, r_d, i_q, i_d;
  logic [5:0] x_q, x_d, k_q, k_d;
  logic [6:0] acc_q, acc_d;
  logic [2:0] rd_slot_q, rd_slot_d;
  logic [1:0] iss_q, iss_d, cap_slot_q, cap_slot_d;
  logic       win_vld_q, win_vld_d;
  logic       cen_q, cen_d, cap_q, cap_d;
  logic [ROM_AW-1:0] a_q, a_d;
  logic       vld_q, busy_q, done_q, err_q, err_d;
  logic       sh_en;
  logic [5:0] cs, col;
  logic [7:0] row;
  logic [ROM_AW-1:0] addr;

  // Logical column i-1+slot, clamped into the source ROI
  always_comb begin
    cs  = 6'(i_q) + 6'(rd_slot_q[1:0]);
    col = (cs == 6'd0) ? 6'd0 : cs - 6'd1;
    if (col > 6'(step_q)) col = 6'(step_q);
    row  = 8'(v0_q) + 8'(r_q);
    addr = ROM_AW'(int'(row) * IMG_W + int'(h0_q) + int'(col));
  end

  always_comb begin
    state_d    = state_q;
    v0_d       = v0_q;
    h0_d       = h0_q;
    step_d     = step_q;
    sh_d       = sh_q;
    den_d      = den_q;
    r_d        = r_q;
    x_d        = x_q;
    i_d        = i_q;
    k_d        = k_q;
    acc_d      = acc_q;
    rd_slot_d  = rd_slot_q;
    win_vld_d  = win_vld_q;
    err_d      = err_q;
    a_d        = a_q;
    iss_d      = iss_q;
    cen_d      = 1'b1;
    cap_d      = ~cen_q;
    cap_slot_d = iss_q;
    sh_en      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          v0_d   = V0;
          h0_d   = H0;
          step_d = SW - 5'd1;
          sh_d   = SH;
          den_d  = TW - 6'd1;
          err_d  = 1'b0;
          if (SW < 5'd2 || TW < 6'd2) begin
            err_d   = 1'b1;
            state_d = S_FIN;
          end else begin
            r_d       = '0;
            x_d       = '0;
            acc_d     = '0;
            i_d       = '0;
            k_d       = '0;
            win_vld_d = 1'b0;
            rd_slot_d = '0;
            state_d   = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        if (!rd_slot_q[2]) begin
          cen_d     = 1'b0;
          a_d       = addr;
          iss_d     = rd_slot_q[1:0];
          rd_slot_d = rd_slot_q + 3'd1;
        end else if (cen_q) begin
          // last capture (if any) lands at this edge
          win_vld_d = 1'b1;
          state_d   = S_PRESENT;
        end
      end
      S_PRESENT: begin
        if (out_ready) begin
          if (x_q < den_q) begin
            x_d     = x_q + 6'd1;
            acc_d   = acc_q + 7'(step_q);
            k_d     = '0;
            state_d = S_ADVANCE;
          end else if (6'(r_q) + 6'd1 < 6'(sh_q)) begin
            r_d       = r_q + 5'd1;
            x_d       = '0;
            acc_d     = '0;
            i_d       = '0;
            k_d       = '0;
            win_vld_d = 1'b0;
            rd_slot_d = '0;
            state_d   = S_FETCH;
          end else begin
            state_d = S_FIN;
          end
        end
      end
      S_ADVANCE: begin
        if (acc_q >= 7'(den_q)) begin
          acc_d = acc_q - 7'(den_q);
          i_d   = i_q + 5'd1;
          k_d   = k_q + 6'd1;
        end else begin
          state_d = S_FETCH;
          if (win_vld_q && k_q < 6'd4) begin
            sh_en     = (k_q != 6'd0);
            rd_slot_d = 3'd4 - k_q[2:0];
          end else begin
            win_vld_d = 1'b0;
            rd_slot_d = '0;
          end
        end
      end
      S_FIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      v0_q       <= '0;
      h0_q       <= '0;
      step_q     <= '0;
      sh_q       <= '0;
      den_q      <= '0;
      r_q        <= '0;
      x_q        <= '0;
      i_q        <= '0;
      k_q        <= '0;
      acc_q      <= '0;
      rd_slot_q  <= '0;
      win_vld_q  <= 1'b0;
      err_q      <= 1'b0;
      a_q        <= '0;
      iss_q      <= '0;
      cen_q      <= 1'b1;
      cap_q      <= 1'b0;
      cap_slot_q <= '0;
      vld_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      v0_q       <= v0_d;
      h0_q       <= h0_d;
      step_q     <= step_d;
      sh_q       <= sh_d;
      den_q      <= den_d;
      r_q        <= r_d;
      x_q        <= x_d;
      i_q        <= i_d;
      k_q        <= k_d;
      acc_q      <= acc_d;
      rd_slot_q  <= rd_slot_d;
      win_vld_q  <= win_vld_d;
      err_q      <= err_d;
      a_q        <= a_d;
      iss_q      <= iss_d;
      cen_q      <= cen_d;
      cap_q      <= cap_d;
      cap_slot_q <= cap_slot_d;
      vld_q      <= (state_d == S_PRESENT);
      busy_q     <= (state_d != S_IDLE);
      done_q     <= (state_d == S_FIN);
    end
  end

  tap_window4 u_win (
    .CLK      (CLK),
    .RST      (RST),
    .shift_en (sh_en),
    .shift_k  (k_q[1:0]),
    .wr_en    (cap_q),
    .wr_idx   (cap_slot_q),
    .wr_data  (rom_q),
    .taps     (out_taps)
  );

  assign rom_cen   = cen_q;
  assign rom_a     = a_q;
  assign out_valid = vld_q;
  assign out_num   = acc_q[5:0];
  assign out_den   = den_q;
  assign out_x     = x_q;
  assign out_y     = r_q;
  assign out_last  = vld_q && (x_q == den_q) &&
                     (6'(r_q) + 6'd1 == 6'(sh_q));
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_bicubic_tap_fetch.sv
// Scoreboard bench for bicubic_tap_fetch with a behavioural ImgROM.
// Expected reads and tap sets come from a division-based reference.
module tb_bicubic_tap_fetch;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        start = 1'b0;
  logic [6:0]  V0 = '0;
  logic [6:0]  H0 = '0;
  logic [4:0]  SW = '0;
  logic [4:0]  SH = '0;
  logic [5:0]  TW = '0;
  logic        rom_cen;
  logic [13:0] rom_a;
  logic [7:0]  rom_q = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_taps;
  logic [5:0]  out_num, out_den, out_x;
  logic [4:0]  out_y;
  logic        out_last, busy, done, err;

  typedef struct packed {
    logic [31:0] taps;
    logic [5:0]  num;
    logic [5:0]  den;
    logic [5:0]  x;
    logic [4:0]  y;
    logic        last;
  } exp_t;

  exp_t sb[$];
  int   rdq[$];
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  int   hs_cnt = 0;

  always #5 CLK = ~CLK;

  bicubic_tap_fetch dut (
    .CLK       (CLK),
    .RST       (RST),
    .start     (start),
    .V0        (V0),
    .H0        (H0),
    .SW        (SW),
    .SH        (SH),
    .TW        (TW),
    .rom_cen   (rom_cen),
    .rom_a     (rom_a),
    .rom_q     (rom_q),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_taps  (out_taps),
    .out_num   (out_num),
    .out_den   (out_den),
    .out_x     (out_x),
    .out_y     (out_y),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  function automatic logic [7:0] romf(input int a);
    return 8'(a * 37 + (a >> 4));
  endfunction

  always @(posedge CLK)
    if (!rom_cen) rom_q <= romf(int'(rom_a));

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  always @(negedge CLK) begin : mon
    exp_t e;
    if (!RST) begin
      if (!rom_cen) begin
        if (rdq.size() == 0) chk("rd_extra", 32'(rom_a), 32'hffff_ffff);
        else chk("rd_addr", 32'(rom_a), 32'(rdq.pop_front()));
      end
      if (done) done_cnt++;
      if (out_valid && out_ready) begin
        hs_cnt++;
        if (sb.size() == 0) chk("hs_extra", 1, 0);
        else begin
          e = sb.pop_front();
          chk("taps", out_taps, e.taps);
          chk("num", 32'(out_num), 32'(e.num));
          chk("den", 32'(out_den), 32'(e.den));
          chk("x", 32'(out_x), 32'(e.x));
          chk("y", 32'(out_y), 32'(e.y));
          chk("last", 32'(out_last), 32'(e.last));
        end
      end
    end
  end

  function automatic int addr(input int v0, input int h0, input int sw,
                              input int r, input int c);
    int pc;
    pc = (c < 0) ? 0 : ((c > sw - 1) ? sw - 1 : c);
    return (v0 + r) * 100 + h0 + pc;
  endfunction

  task automatic model(input int v0, input int h0, input int sw,
                       input int sh, input int tw);
    for (int r = 0; r < sh; r++) begin
      int ip;
      ip = 0;
      for (int x = 0; x < tw; x++) begin
        int i, n, k, lo;
        exp_t e;
        i  = x * (sw - 1) / (tw - 1);
        n  = x * (sw - 1) % (tw - 1);
        k  = i - ip;
        lo = (x == 0 || k >= 4) ? 0 : 4 - k;
        for (int j = lo; j < 4; j++)
          rdq.push_back(addr(v0, h0, sw, r, i - 1 + j));
        for (int j = 0; j < 4; j++)
          e.taps[8*j +: 8] = romf(addr(v0, h0, sw, r, i - 1 + j));
        e.num  = 6'(n);
        e.den  = 6'(tw - 1);
        e.x    = 6'(x);
        e.y    = 5'(r);
        e.last = (x == tw - 1) && (r == sh - 1);
        sb.push_back(e);
        ip = i;
      end
    end
  endtask

  task automatic kick(input int v0, input int h0, input int sw,
                      input int sh, input int tw);
    @(posedge CLK); #1;
    V0 = 7'(v0); H0 = 7'(h0); SW = 5'(sw); SH = 5'(sh); TW = 6'(tw);
    start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
  endtask

  task automatic run(input int v0, input int h0, input int sw,
                     input int sh, input int tw, input bit bp,
                     input bit bad);
    int d0, hc, n;
    logic [31:0] st, sm;
    if (!bad) model(v0, h0, sw, sh, tw);
    d0 = done_cnt;
    hc = hs_cnt;
    out_ready = !bp;
    kick(v0, h0, sw, sh, tw);
    chk("busy_run", 32'(busy), 1);
    n = 0;
    while (done_cnt == d0 && n < 3000) begin
      if (bp && out_valid && !out_ready) begin
        st = out_taps;
        sm = 32'({out_num, out_x, out_y, out_last});
        repeat (5) begin
          @(negedge CLK);
          chk("bp_taps", out_taps, st);
          chk("bp_misc", 32'({out_num, out_x, out_y, out_last}), sm);
          chk("bp_cen", 32'(rom_cen), 1);
          chk("bp_vld", 32'(out_valid), 1);
          @(posedge CLK); #1;
          n++;
        end
        out_ready = 1'b1;
      end else begin
        @(posedge CLK); #1;
        n++;
      end
    end
    chk("done_low", 32'(done), 0);
    @(posedge CLK); #1;
    chk("done_cnt", 32'(done_cnt - d0), 1);
    chk("idle", 32'(busy), 0);
    chk("hs_cnt", 32'(hs_cnt - hc), bad ? 0 : 32'(sh * tw));
    chk("err", 32'(err), 32'(bad));
    chk("sb_left", 32'(sb.size()), 0);
    chk("rd_left", 32'(rdq.size()), 0);
    out_ready = 1'b1;
  endtask

  initial begin
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_cen", 32'(rom_cen), 1);
    chk("rst_a", 32'(rom_a), 0);
    chk("rst_vld", 32'(out_valid), 0);
    chk("rst_taps", out_taps, 0);
    chk("rst_nd", 32'({out_num, out_den, out_x, out_y, out_last}), 0);
    chk("rst_bde", 32'({busy, done, err}), 0);
    RST = 1'b0;

    run(10, 20, 4, 1, 7, 1'b0, 1'b0);
    run(10, 20, 8, 1, 3, 1'b0, 1'b0);
    run(10, 20, 4, 1, 7, 1'b1, 1'b0);
    run(5, 3, 6, 3, 2, 1'b0, 1'b0);
    run(10, 20, 1, 1, 7, 1'b0, 1'b1);
    repeat (3) @(posedge CLK);
    #1 chk("err_sticky", 32'(err), 1);
    run(0, 0, 3, 1, 63, 1'b0, 1'b0);
    run(100, 50, 31, 2, 5, 1'b0, 1'b0);
    run(10, 20, 5, 1, 1, 1'b0, 1'b1);

    model(10, 20, 4, 1, 7);
    kick(10, 20, 4, 1, 7);
    @(posedge CLK); #2;
    RST = 1'b1;
    #1;
    chk("mid_cen", 32'(rom_cen), 1);
    chk("mid_vld", 32'(out_valid), 0);
    chk("mid_busy", 32'(busy), 0);
    chk("mid_done", 32'(done), 0);
    @(posedge CLK); #1;
    RST = 1'b0;
    sb.delete();
    rdq.delete();
    run(10, 20, 4, 1, 7, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
